// File: rtl/balance_count.sv
// balance_count: classifies WIDTH-bit samples by ones/zeros balance or repetition
// and keeps saturating match, streak, max-streak statistics plus a threshold pulse.
module balance_count #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic [CNT_W-1:0] streak,
    output logic [CNT_W-1:0] max_streak,
    output logic             thr_hit
);

    localparam int OW = $clog2(WIDTH + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THR_V = CNT_W'(THRESH);
    localparam logic [OW-1:0] W_V = OW'(WIDTH);

    logic [OW-1:0]    ones;
    logic [OW-1:0]    ones2;
    logic             cls;
    logic             valid_q;
    logic             match_q;
    logic [WIDTH-1:0] prev_q;
    logic             prev_ok;
    logic             fired_q;
    logic [CNT_W-1:0] streak_nx;

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + OW'(in[i]);
        end
    end

    // ones == zeros  <=>  2*ones == WIDTH; odd WIDTH never balances
    assign ones2 = {ones[OW-2:0], 1'b0};

    always_comb begin
        cls = 1'b0;
        unique case (mode)
            2'b00: cls = (ones2 == W_V);
            2'b01: cls = (ones2 > W_V);
            2'b10: cls = (ones2 < W_V);
            2'b11: cls = prev_ok && (in == prev_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            match_q <= 1'b0;
            prev_q  <= '0;
            prev_ok <= 1'b0;
        end else if (clr) begin
            valid_q <= 1'b0;
            match_q <= 1'b0;
            prev_ok <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                match_q <= cls;
                prev_q  <= in;
                prev_ok <= 1'b1;
            end
        end
    end

    assign streak_nx = (streak == CNT_MAX) ? CNT_MAX : streak + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            streak     <= '0;
            max_streak <= '0;
        end else if (clr) begin
            cnt        <= '0;
            streak     <= '0;
            max_streak <= '0;
        end else if (valid_q) begin
            if (match_q) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
                streak <= streak_nx;
                if (streak_nx > max_streak) begin
                    max_streak <= streak_nx;
                end
            end else begin
                streak <= '0;
            end
        end
    end

    // cnt only grows between clears, so the first cycle at THRESH fires once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_hit <= 1'b0;
            fired_q <= 1'b0;
        end else if (clr) begin
            thr_hit <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            thr_hit <= (cnt == THR_V) && !fired_q;
            if (cnt == THR_V) begin
                fired_q <= 1'b1;
            end
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: doc/balance_count.md
# balance_count

Parametrised successor to the lab-series 4-bit "equal ones/zeros" counter. Samples a WIDTH-bit input word each enabled cycle, classifies it according to a selectable mode, and maintains a saturating match counter, a current-streak counter, a maximum-streak register and a one-shot threshold pulse. It sits as a standalone statistics block, observed by a testbench or a status register bank.

## Interface
Parameters:
- WIDTH, 4, input word width (≥2; odd allowed).
- CNT_W, 8, width of all counters (≥2).
- THRESH, 10, count value that fires thr_hit (1 ≤ THRESH ≤ 2^CNT_W−1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  sample valid: in/mode are captured this cycle.
- clr  in  1  synchronous clear of all statistics and the pipeline.
- mode  in  2  classification mode, sampled with in.
- in  in  WIDTH  data word.
- cnt  out  CNT_W  total matches, saturating.
- sat  out  1  high while cnt == 2^CNT_W−1.
- streak  out  CNT_W  consecutive matching samples, saturating.
- max_streak  out  CNT_W  largest streak value since reset/clr.
- thr_hit  out  1  one-cycle pulse when cnt becomes equal to THRESH.

## Operation
- Modes (ones = popcount(in), zeros = WIDTH−ones):
  - 00 EQUAL: match if ones == zeros (never for odd WIDTH).
  - 01 MORE1: match if ones > zeros.
  - 10 MORE0: match if zeros > ones.
  - 11 REPEAT: match if in equals the previous enabled sample; first enabled sample after reset/clr never matches.
- Stage 1 (register): on en=1, store valid_q=1, match_q=classification; store in as prev sample and set prev_ok. On en=0, valid_q=0; prev sample/prev_ok unchanged (disabled cycles are skipped, not breaks).
- Stage 2 (register) when valid_q=1:
  - match_q=1: cnt += 1 unless saturated; streak += 1 unless saturated; max_streak = max(max_streak, new streak).
  - match_q=0: streak = 0; cnt and max_streak hold.
- valid_q=0: stage 2 holds all state.
- Saturation: cnt and streak stop at 2^CNT_W−1, never wrap.
- thr_hit: registered, high for exactly the cycle after cnt transitions from THRESH−1 to THRESH; never again until clr/reset. Not fired if THRESH is never reached.
- clr (priority over en): next edge zeroes cnt, streak, max_streak, thr_hit, valid_q, match_q, prev_ok. A sample presented with clr=1 is discarded.
- sat is combinational from cnt.

## Timing
- Reset (async, rst_n=0): cnt=0, streak=0, max_streak=0, thr_hit=0, sat=0, valid_q=0, match_q=0, prev_ok=0, prev sample=0. Release takes effect at next edge.
- Latency: sample at edge N → cnt/streak/max_streak updated at edge N+1 (visible after edge N+1, i.e. second cycle after presentation). thr_hit asserted after edge N+2.
- Throughput: one sample per cycle, back-to-back en supported.
- Mode changes per sample take effect immediately; REPEAT history spans mode changes (prev sample updated on every enabled sample regardless of mode).
- Reset mid-stream: in-flight stage-1 sample is lost.
- clr asserted while a sample is in stage 1: that sample is dropped, not counted.

## Test plan
- WIDTH=4, mode 00, en=1, in = 1100,1010,0011,0101,0111,0000 → cnt = 4, streak = 0, max_streak = 4 after final update; thr_hit never pulses (THRESH=10).
- Mode 11, in = 5,5,5,3,3 (en=1, one gap cycle with en=0 between 2nd and 3rd 5) → matches on samples 2,3,5; cnt=3, streak=1, max_streak=2.
- CNT_W=3, mode 01, in=1111 for 10 cycles → cnt and streak stop at 7, sat=1 from cycle cnt reaches 7, no wrap.
- THRESH=3, mode 10, in=0000 ×5 → thr_hit high exactly one cycle, one cycle after cnt becomes 3; cnt ends at 5.
- clr asserted same cycle as a matching sample after cnt=6 → next cycle all outputs 0; discarded sample not counted; next REPEAT sample does not match.
- rst_n pulsed low asynchronously mid-stream (between edges) → all outputs 0 immediately; counting resumes correctly with sample presented after release.
